// File: rtl/sap_out_display.sv
// SAP-1 output port: captures the W-bus into an output register, converts it to
// BCD with a sequential double-dabble and scans three multiplexed 7-segment digits.
module sap_out_display #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        lo,
  input  logic [7:0]  wbus,
  output logic [7:0]  out_reg,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  state_t      state_r;
  logic [19:0] shift_r;
  logic [2:0]  step_r;
  logic        pending_r;
  logic [15:0] div_r;
  logic [1:0]  idx_r;
  logic [3:0]  digit_s;
  logic [2:0]  an_s;
  logic        blank_s;
  logic [6:0]  seg_s;

  // One double-dabble step: correct each BCD nibble, then shift the whole register.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    t[19:16] = (t[19:16] >= 4'd5) ? t[19:16] + 4'd3 : t[19:16];
    t[15:12] = (t[15:12] >= 4'd5) ? t[15:12] + 4'd3 : t[15:12];
    t[11:8]  = (t[11:8]  >= 4'd5) ? t[11:8]  + 4'd3 : t[11:8];
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // Output capture and conversion FSM; a LATCH exit may chain straight into CONV.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      out_reg   <= 8'd0;
      bcd       <= 12'd0;
      shift_r   <= 20'd0;
      step_r    <= 3'd0;
      state_r   <= IDLE;
      pending_r <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (lo) begin
        out_reg <= wbus;
      end
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (lo) begin
            state_r <= CONV;
            shift_r <= {12'd0, wbus};
            step_r  <= 3'd0;
            busy    <= 1'b1;
          end
        end
        CONV: begin
          shift_r <= dabble_step(shift_r);
          step_r  <= step_r + 3'd1;
          if (lo) begin
            pending_r <= 1'b1;
          end
          if (step_r == 3'd7) begin
            state_r <= LATCH;
          end
        end
        LATCH: begin
          bcd  <= shift_r[19:8];
          done <= 1'b1;
          if (lo) begin
            state_r   <= CONV;
            shift_r   <= {12'd0, wbus};
            step_r    <= 3'd0;
            pending_r <= 1'b0;
          end else if (pending_r) begin
            state_r   <= CONV;
            shift_r   <= {12'd0, out_reg};
            step_r    <= 3'd0;
            pending_r <= 1'b0;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  // Digit selection with leading-zero blanking of hundreds and tens.
  always_comb begin
    digit_s = bcd[3:0];
    an_s    = 3'b110;
    blank_s = 1'b0;
    case (idx_r)
      2'd0: begin
        digit_s = bcd[3:0];
        an_s    = 3'b110;
        blank_s = 1'b0;
      end
      2'd1: begin
        digit_s = bcd[7:4];
        an_s    = 3'b101;
        blank_s = (bcd[11:4] == 8'd0);
      end
      2'd2: begin
        digit_s = bcd[11:8];
        an_s    = 3'b011;
        blank_s = (bcd[11:8] == 4'd0);
      end
      default: begin
        digit_s = bcd[3:0];
        an_s    = 3'b110;
        blank_s = 1'b0;
      end
    endcase
    if (blank_s) begin
      seg_s = 7'h7F;
    end else begin
      seg_s = seg_decode(digit_s);
    end
  end

  // Free-running scan divider; segment and anode outputs follow the index a cycle later.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_r <= 16'd0;
      idx_r <= 2'd0;
      an    <= 3'b110;
      seg   <= 7'h40;
    end else begin
      if (div_r == DIV_LAST) begin
        div_r <= 16'd0;
        idx_r <= (idx_r == 2'd2) ? 2'd0 : idx_r + 2'd1;
      end else begin
        div_r <= div_r + 16'd1;
      end
      an  <= an_s;
      seg <= seg_s;
    end
  end

endmodule

// File: tb/tb_sap_out_display.sv
// Randomized self-checking bench for sap_out_display against a decimal
// arithmetic reference model of conversion, timing and display scanning.
module tb_sap_out_display;

  localparam int unsigned SDIV = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        lo = 1'b0;
  logic [7:0]  wbus = 8'd0;
  logic [7:0]  out_reg;
  logic [11:0] bcd;
  logic        busy;
  logic        done;
  logic [6:0]  seg;
  logic [2:0]  an;

  int n_checks = 0;
  int n_fail = 0;
  logic [11:0] prev_bcd = 12'd0;
  logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  sap_out_display #(.SCAN_DIV(SDIV)) dut (
    .clk(clk), .clr(clr), .lo(lo), .wbus(wbus), .out_reg(out_reg),
    .bcd(bcd), .busy(busy), .done(done), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Issue one conversion of v with lo for a single edge and check its full timeline.
  task automatic convert(input logic [7:0] v);
    logic [11:0] exp;
    exp = to_bcd(int'(v));
    lo = 1'b1; wbus = v;
    tick;
    lo = 1'b0; wbus = 8'($urandom);
    n_checks++;
    if (out_reg !== v || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start v=%0d: out_reg=%h busy=%b done=%b, want %h 1 0", v, out_reg, busy, done, v);
    end
    for (int i = 1; i <= 8; i++) begin
      tick;
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || bcd !== prev_bcd) begin
        n_fail++;
        $display("FAIL conv v=%0d k+%0d: busy=%b done=%b bcd=%h, want 1 0 %h", v, i, busy, done, bcd, prev_bcd);
      end
    end
    tick;
    n_checks++;
    if (done !== 1'b1 || bcd !== exp || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latch v=%0d: done=%b bcd=%h busy=%b, want 1 %h 0", v, done, bcd, busy, exp);
    end
    prev_bcd = exp;
    tick;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width v=%0d: done=%b, want 0", v, done);
    end
  endtask

  task automatic test_reset;
    repeat (3) tick;
    n_checks++;
    if (out_reg !== 8'd0 || bcd !== 12'd0 || busy !== 1'b0 || done !== 1'b0 ||
        an !== 3'b110 || seg !== 7'h40) begin
      n_fail++;
      $display("FAIL reset: out_reg=%h bcd=%h busy=%b done=%b an=%b seg=%h, want 00 000 0 0 110 40",
               out_reg, bcd, busy, done, an, seg);
    end
    clr = 1'b1;
    convert(8'd42);
  endtask

  task automatic test_random;
    convert(8'hFF);
    for (int i = 0; i < 10; i++) begin
      convert(8'($urandom));
    end
  endtask

  // Convert v, then watch the scan: order, dwell time and segment pattern per digit.
  task automatic test_display(input logic [7:0] v);
    int h, t, o, run, seen;
    logic [2:0] last_an;
    logic [2:0] want_next;
    logic [6:0] exp_seg;
    convert(v);
    h = int'(v) / 100; t = (int'(v) / 10) % 10; o = int'(v) % 10;
    last_an = an; run = 0; seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (an == 3'b110) exp_seg = pat[o];
      else if (an == 3'b101) exp_seg = (h == 0 && t == 0) ? 7'h7F : pat[t];
      else if (an == 3'b011) exp_seg = (h == 0) ? 7'h7F : pat[h];
      else exp_seg = 7'hXX;
      n_checks++;
      if (seg !== exp_seg) begin
        n_fail++;
        $display("FAIL scan_seg v=%0d an=%b: seg=%h, want %h", v, an, seg, exp_seg);
      end
      if (an !== last_an) begin
        want_next = (last_an == 3'b110) ? 3'b101 : (last_an == 3'b101) ? 3'b011 : 3'b110;
        n_checks++;
        if (an !== want_next || (seen > 0 && run != int'(SDIV))) begin
          n_fail++;
          $display("FAIL scan_order v=%0d: an=%b after %b run=%0d, want %b run=%0d",
                   v, an, last_an, run, want_next, SDIV);
        end
        seen++; run = 0; last_an = an;
      end
      run++;
      tick;
    end
    n_checks++;
    if (seen < 5) begin
      n_fail++;
      $display("FAIL scan_moves v=%0d: transitions=%0d, want >=5", v, seen);
    end
  endtask

  task automatic test_pending;
    int waited;
    lo = 1'b1; wbus = 8'd100;
    tick;
    lo = 1'b0;
    tick; tick;
    lo = 1'b1; wbus = 8'd59;
    tick;
    lo = 1'b0;
    n_checks++;
    if (out_reg !== 8'd59) begin
      n_fail++;
      $display("FAIL pend_capture: out_reg=%0d, want 59", out_reg);
    end
    repeat (6) tick;
    n_checks++;
    if (done !== 1'b1 || bcd !== 12'h100 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_first: done=%b bcd=%h busy=%b, want 1 100 1", done, bcd, busy);
    end
    waited = 0;
    tick;
    while (done !== 1'b1 && waited < 12) begin
      n_checks++;
      if (busy !== 1'b1 || bcd !== 12'h100) begin
        n_fail++;
        $display("FAIL pend_hold: busy=%b bcd=%h, want 1 100", busy, bcd);
      end
      tick; waited++;
    end
    n_checks++;
    if (done !== 1'b1 || waited < 8 || waited > 9 || bcd !== 12'h059) begin
      n_fail++;
      $display("FAIL pend_second: done=%b after %0d bcd=%h, want 1 after 8..9 059", done, waited, bcd);
    end
    tick;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_end: done=%b busy=%b, want 0 0", done, busy);
    end
    prev_bcd = 12'h059;
  endtask

  task automatic test_back_to_back;
    lo = 1'b1; wbus = 8'd5;
    tick;
    lo = 1'b0;
    repeat (8) tick;
    lo = 1'b1; wbus = 8'h0A;
    tick;
    lo = 1'b0;
    n_checks++;
    if (done !== 1'b1 || bcd !== 12'h005 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b bcd=%h busy=%b, want 1 005 1", done, bcd, busy);
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1 || bcd !== 12'h005) begin
        n_fail++;
        $display("FAIL b2b_conv %0d: done=%b busy=%b bcd=%h, want 0 1 005", i, done, busy, bcd);
      end
    end
    tick;
    n_checks++;
    if (done !== 1'b1 || bcd !== 12'h010 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b bcd=%h busy=%b, want 1 010 0", done, bcd, busy);
    end
    repeat (3) tick;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_nopend: busy=%b done=%b, want 0 0", busy, done);
    end
    prev_bcd = 12'h010;
  endtask

  task automatic test_reset_mid;
    lo = 1'b1; wbus = 8'hC8;
    tick;
    lo = 1'b0;
    repeat (4) tick;
    clr = 1'b0;
    #1;
    n_checks++;
    if (out_reg !== 8'd0 || bcd !== 12'd0 || busy !== 1'b0 || done !== 1'b0 ||
        an !== 3'b110 || seg !== 7'h40) begin
      n_fail++;
      $display("FAIL reset_mid: out_reg=%h bcd=%h busy=%b done=%b an=%b seg=%h, want 00 000 0 0 110 40",
               out_reg, bcd, busy, done, an, seg);
    end
    tick; tick;
    clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || bcd !== 12'd0) begin
        n_fail++;
        $display("FAIL reset_quiet %0d: done=%b busy=%b bcd=%h, want 0 0 000", i, done, busy, bcd);
      end
    end
    prev_bcd = 12'd0;
  endtask

  task automatic test_sweep;
    for (int v = 0; v < 256; v++) begin
      convert(8'(v));
    end
  endtask

  initial begin
    test_reset;
    test_random;
    test_display(8'h07);
    test_display(8'd205);
    test_display(8'($urandom));
    test_pending;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
